// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax row scheduler.
package softmax_pkg;

    // Scheduler FSM encoding; exposed on the debug state output of the top.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_GAP  = 3'd2
    } sched_state_t;

    localparam int D_W_DEF     = 16;
    localparam int NUM_DEF     = 16;
    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 1024;

    typedef logic [D_W_DEF-1:0] word_t;

    // Requester index reached by stepping 'off' places past 'ptr', wrapping at n.
    function automatic int rr_index(input int ptr, input int off, input int n);
        return (ptr + off) % n;
    endfunction

endpackage

// File: rtl/softmax_row_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1 .. ptr+N (mod N) and
// grants the first requester found; gnt is one-hot or all zero.
module rr_arbiter
    import softmax_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] id
);

    localparam int ID_W = $clog2(N);

    logic [ID_W-1:0] idx;

    // Walk the search order backwards so the earliest candidate is written last and wins.
    always_comb begin
        gnt = '0;
        id  = '0;
        idx = '0;
        for (int off = N; off >= 1; off--) begin
            idx = ID_W'(rr_index(int'(ptr), off, N));
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                id       = idx;
            end
        end
    end

endmodule

// File: rtl/softmax_row_sched.sv
// Shares one safe-softmax unit among N_REQ requesters. Grants rows round-robin,
// holds the granted row stable for the unit, returns the result tagged with the
// owner ID and aborts a row through a watchdog if the unit never answers.
//
// Handshake: a requester holds I_REQ level-high until it sees its O_GNT pulse;
// the row is captured on that same edge. Toward the unit O_SM_START is a level
// held for the whole row and I_SM_VLD is a one-cycle pulse carrying I_SM_DATA.
// Results leave as a one-cycle O_RES_VLD (or O_ERR) pulse; O_RES_DATA holds.
module softmax_row_sched
    import softmax_pkg::*;
#(
    parameter int D_W     = D_W_DEF,
    parameter int NUM     = NUM_DEF,
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                                     I_CLK,
    input  logic                                     I_RST_N,
    input  logic [N_REQ-1:0]                         I_REQ,
    input  logic [0:N_REQ-1][0:NUM-1][D_W-1:0]       I_REQ_DATA,
    output logic [N_REQ-1:0]                         O_GNT,
    output logic                                     O_SM_START,
    output logic [0:NUM-1][D_W-1:0]                  O_SM_DATA,
    input  logic                                     I_SM_VLD,
    input  logic [0:NUM-1][D_W-1:0]                  I_SM_DATA,
    output logic                                     O_RES_VLD,
    output logic [$clog2(N_REQ)-1:0]                 O_RES_ID,
    output logic [0:NUM-1][D_W-1:0]                  O_RES_DATA,
    output logic                                     O_ERR,
    output logic                                     O_BUSY,
    output sched_state_t                             O_STATE
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    sched_state_t            state, state_nxt;
    logic [N_REQ-1:0]        arb_gnt;
    logic [ID_W-1:0]         arb_id;
    logic [0:NUM-1][D_W-1:0] row_buf;
    logic [ID_W-1:0]         cur_id;
    logic [ID_W-1:0]         ptr;
    logic [WD_W-1:0]         wdog;
    logic                    take, done, wdog_hit;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (I_REQ),
        .ptr (ptr),
        .gnt (arb_gnt),
        .id  (arb_id)
    );

    // Event decode; a result pulse beats a coincident watchdog expiry.
    assign take       = (state == S_IDLE) && (|I_REQ);
    assign done       = (state == S_RUN) && I_SM_VLD;
    assign wdog_hit   = (state == S_RUN) && !I_SM_VLD && (wdog == WD_W'(TIMEOUT - 1));
    assign O_SM_START = (state == S_RUN);
    assign O_SM_DATA  = row_buf;
    assign O_BUSY     = (state != S_IDLE);
    assign O_STATE    = state;

    // State register; reset drops start asynchronously through the state decode.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic: one row at a time, one start-low cycle between rows.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (take) state_nxt = S_RUN;
            S_RUN:   if (done || wdog_hit) state_nxt = S_GAP;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Row capture, owner tracking, watchdog and registered result pulses.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            row_buf    <= '0;
            cur_id     <= '0;
            ptr        <= ID_W'(N_REQ - 1);
            wdog       <= '0;
            O_GNT      <= '0;
            O_RES_VLD  <= 1'b0;
            O_RES_ID   <= '0;
            O_RES_DATA <= '0;
            O_ERR      <= 1'b0;
        end else begin
            O_GNT     <= '0;
            O_RES_VLD <= 1'b0;
            O_ERR     <= 1'b0;
            if (take) begin
                row_buf <= I_REQ_DATA[arb_id];
                O_GNT   <= arb_gnt;
                cur_id  <= arb_id;
                ptr     <= arb_id;
                wdog    <= '0;
            end
            if (state == S_RUN && wdog != '1) begin
                wdog <= wdog + 1'b1;
            end
            if (done) begin
                O_RES_DATA <= I_SM_DATA;
                O_RES_ID   <= cur_id;
                O_RES_VLD  <= 1'b1;
            end else if (wdog_hit) begin
                O_RES_ID <= cur_id;
                O_ERR    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_softmax_row_sched.sv
// Directed bench for softmax_row_sched with a softmax stub that answers 40
// cycles after it accepts start and returns the bitwise-inverted row.
module tb_softmax_row_sched;
    import softmax_pkg::*;

    localparam int D_W     = 16;
    localparam int NUM     = 16;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 40;
    localparam int RW      = NUM * D_W;
    localparam int EW      = 2 + 2 + 8 + RW;

    typedef logic [0:NUM-1][D_W-1:0] row_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]                   req;
    logic [0:N_REQ-1][0:NUM-1][D_W-1:0] req_data;
    logic [N_REQ-1:0]                   o_gnt;
    logic                               sm_start;
    row_t                               sm_data;
    logic                               sm_vld;
    row_t                               sm_odata;
    logic                               res_vld;
    logic [1:0]                         res_id;
    row_t                               res_data;
    logic                               o_err;
    logic                               o_busy;
    sched_state_t                       o_state;
    logic                               mute;

    softmax_row_sched #(.D_W(D_W), .NUM(NUM), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .I_CLK      (clk),
        .I_RST_N    (rst_n),
        .I_REQ      (req),
        .I_REQ_DATA (req_data),
        .O_GNT      (o_gnt),
        .O_SM_START (sm_start),
        .O_SM_DATA  (sm_data),
        .I_SM_VLD   (sm_vld),
        .I_SM_DATA  (sm_odata),
        .O_RES_VLD  (res_vld),
        .O_RES_ID   (res_id),
        .O_RES_DATA (res_data),
        .O_ERR      (o_err),
        .O_BUSY     (o_busy),
        .O_STATE    (o_state)
    );

    // ---------------- softmax stub ----------------
    int   stub_st;
    int   stub_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_st  <= 0;
            stub_cnt <= 0;
            sm_vld   <= 1'b0;
            sm_odata <= '0;
        end else begin
            sm_vld <= 1'b0;
            case (stub_st)
                0: if (sm_start) begin stub_st <= 1; stub_cnt <= 0; end
                1: begin
                    if (!sm_start) stub_st <= 0;
                    else if (!mute && stub_cnt == LAT) begin
                        sm_vld   <= 1'b1;
                        sm_odata <= ~sm_data;
                        stub_st  <= 2;
                    end else stub_cnt <= stub_cnt + 1;
                end
                default: stub_st <= 0;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [3:0]    gnt_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic row_t mk_row(input int tag);
        row_t r;
        for (int i = 0; i < NUM; i++) r[i] = D_W'((tag << 8) + i);
        return r;
    endfunction

    function automatic logic [EW-1:0] mk_exp(input logic err, input int id, input int lat, input row_t d);
        row_t dd;
        dd = err ? '0 : d;
        return {~err, err, 2'(id), 8'(lat), dd};
    endfunction

    // Expect a grant of requester id and, 43 cycles later, its inverted row.
    task automatic expect_row(input int id);
        gnt_q.push_back(4'(1 << id));
        exp_q.push_back(mk_exp(1'b0, id, LAT + 3, ~row_t'(req_data[id])));
    endtask

    // Monitor: pops and compares whenever the DUT presents a grant or a result.
    initial begin
        int gnt_cyc;
        logic [EW-1:0] act;
        gnt_cyc = 0;
        forever begin
            @(negedge clk);
            if (o_gnt != 0) begin
                if (gnt_q.size() == 0) chk("unexpected_gnt", EW'(o_gnt), '0);
                else                   chk("gnt", EW'(o_gnt), EW'(gnt_q.pop_front()));
                gnt_cyc = cyc;
            end
            if (res_vld || o_err) begin
                act = {res_vld, o_err, res_id, 8'(cyc - gnt_cyc), (o_err ? row_t'('0) : res_data)};
                if (exp_q.size() == 0) chk("unexpected_result", act, '0);
                else                   chk("result", act, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_reqs(input logic [3:0] mask, input int n0, input int n1, input int n2, input int n3);
        int rem[4];
        int budget;
        rem = '{n0, n1, n2, n3};
        budget = 0;
        @(negedge clk);
        req = mask;
        while ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
            for (int i = 0; i < 4; i++) begin
                if (o_gnt[i] && rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) req[i] = 1'b0;
                end
            end
        end
        chk("grants_outstanding", EW'(rem[0] + rem[1] + rem[2] + rem[3]), '0);
        req = '0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || gnt_q.size() != 0 || o_busy) && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        chk({name, "_exp_left"}, EW'(exp_q.size() + gnt_q.size()), '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b;
        req = '0; req_data = '0; mute = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt",      EW'(o_gnt), '0);
        chk("rst_sm_start", EW'(sm_start), '0);
        chk("rst_res_vld",  EW'({res_vld, o_err, o_busy}), '0);
        chk("rst_res_data", EW'(res_data), '0);
        chk("rst_state",    EW'(o_state), EW'(S_IDLE));
        @(negedge clk) rst_n = 1'b1;

        // 1: single request, row[i]=i, grant next cycle, data isolated after grant
        req_data[2] = mk_row(0);
        expect_row(2);
        @(negedge clk) req = 4'b0100;
        @(negedge clk);
        chk("t1_gnt_latency", EW'(o_gnt), EW'(4'b0100));
        req = '0;
        req_data[2] = mk_row(99);
        @(negedge clk);
        chk("t1_sm_start", EW'(sm_start), EW'(1'b1));
        chk("t1_sm_data_isolated", EW'(sm_data), EW'(mk_row(0)));
        drain("t1");

        // 2: all four request after a fresh reset -> 0,1,2,3
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int r = 0; r < 4; r++) req_data[r] = mk_row(16 + r);
        for (int r = 0; r < 4; r++) expect_row(r);
        run_reqs(4'b1111, 1, 1, 1, 1);
        drain("t2");

        // 3: fairness between 0 and 3
        for (int k = 0; k < 3; k++) begin expect_row(0); expect_row(3); end
        run_reqs(4'b1001, 3, 0, 0, 3);
        drain("t3");

        // 4: watchdog abort, then normal service resumes
        mute = 1'b1;
        req_data[1] = mk_row(33);
        gnt_q.push_back(4'b0010);
        exp_q.push_back(mk_exp(1'b1, 1, TIMEOUT, '0));
        run_reqs(4'b0010, 0, 1, 0, 0);
        b = 0;
        while (!o_err && b < 200) begin @(negedge clk); b++; end
        chk("t4_err_seen", EW'(o_err), EW'(1'b1));
        chk("t4_gap_start_low", EW'({sm_start, o_busy}), EW'(2'b01));
        @(negedge clk);
        chk("t4_idle_start_low", EW'({sm_start, o_busy}), EW'(2'b00));
        mute = 1'b0;
        req_data[0] = mk_row(44);
        expect_row(0);
        run_reqs(4'b0001, 1, 0, 0, 0);
        drain("t4");

        // 5: reset 20 cycles into a row
        req_data[2] = mk_row(55);
        gnt_q.push_back(4'b0100);
        run_reqs(4'b0100, 0, 0, 1, 0);
        repeat (19) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_sm_start", EW'(sm_start), '0);
        chk("t5_busy_state", EW'({o_busy, o_gnt, res_vld, o_err, res_id}), '0);
        chk("t5_res_data", EW'(res_data), '0);
        chk("t5_sm_data", EW'(sm_data), '0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        req_data[1] = mk_row(66);
        req_data[2] = mk_row(77);
        expect_row(1);
        expect_row(2);
        run_reqs(4'b0110, 0, 1, 1, 0);
        drain("t5");

        // 6: req2 raised and withdrawn while a row is running
        req_data[0] = mk_row(88);
        expect_row(0);
        run_reqs(4'b0001, 1, 0, 0, 0);
        repeat (5) @(negedge clk);
        req[2] = 1'b1;
        repeat (10) @(negedge clk);
        req[2] = 1'b0;
        drain("t6");
        repeat (60) @(negedge clk);
        chk("t6_idle", EW'({o_busy, o_state}), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
